// File: rtl/serial_pattern_detector_pkg.sv
// Shared types and defaults for the serial pattern detector and its status counters.
package serial_pattern_detector_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int         DEF_WIDTH   = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1011;
    localparam int         DEF_CNT_W   = 8;

    // Saturating +1 on values up to 32 bits; max is the all-ones value of the caller's width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val == max) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/serial_pattern_detector_if.sv
// Stream-in / status-out bundle of the serial pattern detector.
interface serial_pattern_detector_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             d;
    logic             d_valid;
    logic             clr_cnt;
    logic [WIDTH-1:0] shreg;
    logic             word_valid;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             busy;

    modport master (
        output d, d_valid, clr_cnt,
        input  shreg, word_valid, match, match_count, busy
    );

    modport slave (
        input  d, d_valid, clr_cnt,
        output shreg, word_valid, match, match_count, busy
    );
endinterface

// File: rtl/serial_pattern_detector_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter
    import serial_pattern_detector_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    localparam logic [31:0] MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [CNT_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc)
            count_d = CNT_W'(sat_inc(32'(count_q), MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/serial_pattern_detector.sv
// Overlapping pattern search and WIDTH-bit word framing on a serial bit stream.
// Build option PATTERN_MASK_EN adds a MASK parameter making 0 bits don't-care.
module serial_pattern_detector
    import serial_pattern_detector_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] PATTERN = DEF_PATTERN,
    parameter int               CNT_W   = DEF_CNT_W
`ifdef PATTERN_MASK_EN
    ,
    parameter logic [WIDTH-1:0] MASK    = {WIDTH{1'b1}}
`endif
) (
    input logic                clk,
    input logic                rst,
    serial_pattern_detector_if.slave bus
);
    localparam int               BC_W    = $clog2(WIDTH);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH - 1);

    state_e           state_d, state_q;
    logic [WIDTH-1:0] shreg_d, shreg_q;
    logic [BC_W-1:0]  bit_cnt_d, bit_cnt_q;
    logic             word_valid_d, word_valid_q;
    logic             match_d, match_q;
    logic             last_bit, hit;

    assign last_bit = (bit_cnt_q == BC_LAST);

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        word_valid_d = 1'b0;
        match_d      = 1'b0;
        hit          = 1'b0;
        if (bus.d_valid) begin
            shreg_d      = {shreg_q[WIDTH-2:0], bus.d};
            bit_cnt_d    = last_bit ? '0 : bit_cnt_q + BC_W'(1);
            word_valid_d = last_bit;
`ifdef PATTERN_MASK_EN
            hit = (((shreg_d ^ PATTERN) & MASK) == '0);
`else
            hit = (shreg_d == PATTERN);
`endif
            // The fill-completing bit is the first one whose window holds no reset zeros.
            match_d = hit && ((state_q == RUN) || (state_q == FILL && last_bit));
            case (state_q)
                IDLE:    state_d = FILL;
                FILL:    if (last_bit) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            word_valid_q <= 1'b0;
            match_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            word_valid_q <= word_valid_d;
            match_q      <= match_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (match_q),
        .clr   (bus.clr_cnt),
        .count (bus.match_count)
    );

    assign bus.shreg      = shreg_q;
    assign bus.word_valid = word_valid_q;
    assign bus.match      = match_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
